// File: rtl/adf4158_cfg_rx.sv
// Receive-side decoder for the ADF4158 3-wire configuration stream.
// Frames 32-bit words on LE rising edges, decodes register indices and tracks framing errors.
module adf4158_cfg_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 le,
    input  logic                 data,
    output logic [31:0]          word,
    output logic [3:0]           idx,
    output logic                 word_valid,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [9:0]           reg_written,
    output logic                 all_written,
    output logic                 ramp_en
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Map a raw word to its logical register index; R5/R6 carry two parts selected by bit 23.
    function automatic logic [3:0] decode_idx(input logic [31:0] w);
        logic [3:0] r;
        case (w[2:0])
            3'd0:    r = 4'd0;
            3'd1:    r = 4'd1;
            3'd2:    r = 4'd2;
            3'd3:    r = 4'd3;
            3'd4:    r = 4'd4;
            3'd5:    r = w[23] ? 4'd6 : 4'd5;
            3'd6:    r = w[23] ? 4'd8 : 4'd7;
            3'd7:    r = 4'd9;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // Reset synchronizer: asserts immediately, releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic [SS-1:0] sclk_sync_q;
    logic [SS-1:0] le_sync_q;
    logic [SS-1:0] data_sync_q;
    logic          sclk_hist_q;
    logic          le_hist_q;
    logic          sclk_rise_q;
    logic          le_rise_q;
    logic          le_fall_q;
    logic          data_ev_q;
    logic          sclk_rise_s;
    logic          le_rise_s;
    logic          le_fall_s;

    // Input synchronizers plus one history flop for edge detection on sclk and le.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sclk_sync_q <= '0;
            le_sync_q   <= '0;
            data_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            le_hist_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SS-2:0], sclk};
            le_sync_q   <= {le_sync_q[SS-2:0], le};
            data_sync_q <= {data_sync_q[SS-2:0], data};
            sclk_hist_q <= sclk_sync_q[SS-1];
            le_hist_q   <= le_sync_q[SS-1];
        end
    end

    assign sclk_rise_s = sclk_sync_q[SS-1] & ~sclk_hist_q;
    assign le_rise_s   = le_sync_q[SS-1] & ~le_hist_q;
    assign le_fall_s   = ~le_sync_q[SS-1] & le_hist_q;

    // Registered edge events; data is captured in the same stage so it stays aligned with sclk.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sclk_rise_q <= 1'b0;
            le_rise_q   <= 1'b0;
            le_fall_q   <= 1'b0;
            data_ev_q   <= 1'b0;
        end else begin
            sclk_rise_q <= sclk_rise_s;
            le_rise_q   <= le_rise_s;
            le_fall_q   <= le_fall_s;
            data_ev_q   <= data_sync_q[SS-1];
        end
    end

    logic [0:0]           state_q,       state_d;
    logic [5:0]           bit_cnt_q,     bit_cnt_d;
    logic [31:0]          shift_q,       shift_d;
    logic [31:0]          word_q,        word_d;
    logic [3:0]           idx_q,         idx_d;
    logic                 word_valid_q,  word_valid_d;
    logic                 frame_err_q,   frame_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,     err_cnt_d;
    logic [9:0]           reg_written_q, reg_written_d;
    logic                 ramp_en_q,     ramp_en_d;
    logic [3:0]           dec_idx_s;

    assign dec_idx_s = decode_idx(shift_q);

    // Framing state machine; an le rise takes priority over a coincident sclk rise.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        word_d        = word_q;
        idx_d         = idx_q;
        word_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        err_cnt_d     = err_cnt_q;
        reg_written_d = reg_written_q;
        ramp_en_d     = ramp_en_q;
        case (state_q)
            ST_IDLE: begin
                if (le_fall_q) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 6'd0;
                    shift_d   = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (le_rise_q) begin
                    state_d = ST_IDLE;
                    if (bit_cnt_q == 6'd32) begin
                        word_d        = shift_q;
                        idx_d         = dec_idx_s;
                        word_valid_d  = 1'b1;
                        reg_written_d = reg_written_q | (10'b1 << dec_idx_s);
                        if (dec_idx_s == 4'd0) begin
                            ramp_en_d = shift_q[31];
                        end else begin
                            ramp_en_d = ramp_en_q;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                    end
                end else if (sclk_rise_q) begin
                    shift_d = {shift_q[30:0], data_ev_q};
                    if (bit_cnt_q == 6'd33) begin
                        bit_cnt_d = 6'd33;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 6'd0;
            shift_q       <= 32'd0;
            word_q        <= 32'd0;
            idx_q         <= 4'd0;
            word_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            err_cnt_q     <= '0;
            reg_written_q <= 10'd0;
            ramp_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            word_q        <= word_d;
            idx_q         <= idx_d;
            word_valid_q  <= word_valid_d;
            frame_err_q   <= frame_err_d;
            err_cnt_q     <= err_cnt_d;
            reg_written_q <= reg_written_d;
            ramp_en_q     <= ramp_en_d;
        end
    end

    assign word        = word_q;
    assign idx         = idx_q;
    assign word_valid  = word_valid_q;
    assign frame_err   = frame_err_q;
    assign err_cnt     = err_cnt_q;
    assign reg_written = reg_written_q;
    assign all_written = &reg_written_q;
    assign ramp_en     = ramp_en_q;

endmodule

// File: tb/tb_adf4158_cfg_rx.sv
// Self-checking bench for adf4158_cfg_rx: table vectors, hand sequences and random frames
// checked against a frame-level reference model.
module tb_adf4158_cfg_rx;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        le;
    logic        data;
    logic [31:0] word;
    logic [3:0]  idx;
    logic        word_valid;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic [9:0]  reg_written;
    logic        all_written;
    logic        ramp_en;

    adf4158_cfg_rx #(.SYNC_STAGES(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .le(le), .data(data),
        .word(word), .idx(idx), .word_valid(word_valid), .frame_err(frame_err),
        .err_cnt(err_cnt), .reg_written(reg_written), .all_written(all_written),
        .ramp_en(ramp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int wv_cnt;
    int fe_cnt;

    // Pulse counters: a pulse held two cycles counts twice.
    always @(negedge clk) begin
        if (word_valid === 1'b1) wv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    // Reference model state, at frame granularity.
    logic [31:0] m_word;
    int          m_idx;
    logic [9:0]  m_regw;
    int          m_err;
    logic        m_ramp;

    function automatic int ref_idx(input logic [31:0] w);
        int a;
        int sel;
        a   = int'(w) & 7;
        sel = (int'(w >> 23)) & 1;
        if (a < 5) return a;
        if (a == 5) return 5 + sel;
        if (a == 6) return 7 + sel;
        return 9;
    endfunction

    task automatic model_reset();
        m_word = 32'd0; m_idx = 0; m_regw = 10'd0; m_err = 0; m_ramp = 1'b0;
    endtask

    task automatic model_frame(input logic [63:0] bits, input int n);
        if (n == 32) begin
            m_word = bits[31:0];
            m_idx  = ref_idx(bits[31:0]);
            m_regw[m_idx] = 1'b1;
            if (m_idx == 0) m_ramp = bits[31];
        end else begin
            m_err = (m_err >= 255) ? 255 : m_err + 1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Shift n bits (MSB first) between an le fall and rise, then allow the pipeline to settle.
    task automatic send_frame(input logic [63:0] bits, input int n);
        le = 1'b0;
        #100;
        for (int i = n - 1; i >= 0; i--) begin
            data = bits[i];
            #50 sclk = 1'b1;
            #50 sclk = 1'b0;
        end
        #50 le = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name);
        chk({name, ".word"}, word, m_word);
        chk({name, ".idx"}, idx, m_idx);
        chk({name, ".err_cnt"}, err_cnt, m_err);
        chk({name, ".reg_written"}, reg_written, m_regw);
        chk({name, ".all_written"}, all_written, &m_regw);
        chk({name, ".ramp_en"}, ramp_en, m_ramp);
    endtask

    task automatic apply(input logic [63:0] bits, input int n, input string name);
        int wv0;
        int fe0;
        wv0 = wv_cnt;
        fe0 = fe_cnt;
        send_frame(bits, n);
        model_frame(bits, n);
        chk({name, ".wv_pulses"}, wv_cnt - wv0, (n == 32) ? 1 : 0);
        chk({name, ".fe_pulses"}, fe_cnt - fe0, (n == 32) ? 0 : 1);
        check_outputs(name);
    endtask

    typedef struct {
        logic [31:0] w;
        logic [3:0]  exp_idx;
        logic        exp_ramp;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int wv0;
        int fe0;
        vectors = 0; miscompares = 0; wv_cnt = 0; fe_cnt = 0;

        // Expected indices and ramp_en written as constants from the register map.
        tbl[0]  = '{32'h8F8C_0000, 4'd0, 1'b1};
        tbl[1]  = '{32'h0000_0007, 4'd9, 1'b1};
        tbl[2]  = '{32'h0000_0006, 4'd7, 1'b1};
        tbl[3]  = '{32'h0080_0006, 4'd8, 1'b1};
        tbl[4]  = '{32'h0000_0005, 4'd5, 1'b1};
        tbl[5]  = '{32'h0080_0005, 4'd6, 1'b1};
        tbl[6]  = '{32'h0018_0104, 4'd4, 1'b1};
        tbl[7]  = '{32'h0000_0043, 4'd3, 1'b1};
        tbl[8]  = '{32'h0040_8002, 4'd2, 1'b1};
        tbl[9]  = '{32'h0000_0001, 4'd1, 1'b1};
        tbl[10] = '{32'h0F8C_0000, 4'd0, 1'b0};
        tbl[11] = '{32'h8F8C_0000, 4'd0, 1'b1};
        tbl[12] = '{32'hFF7F_FFF0, 4'd0, 1'b1};

        rst_n = 1'b0; sclk = 1'b0; le = 1'b1; data = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.word_valid", word_valid, 1'b0);
        chk("reset.frame_err", frame_err, 1'b0);

        for (int i = 0; i < 13; i++) begin
            apply({32'd0, tbl[i].w}, 32, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.const_idx", i), idx, tbl[i].exp_idx);
            chk($sformatf("tbl%0d.const_ramp", i), ramp_en, tbl[i].exp_ramp);
        end
        chk("seq.all_written", all_written, 1'b1);
        chk("seq.err_cnt_zero", err_cnt, 8'd0);

        // Short and long frames leave the word untouched.
        apply(64'h0000_0000_1234_5673, 31, "short31");
        apply(64'h0000_0001_2345_6783, 33, "long33");
        chk("err.err_cnt_two", err_cnt, 8'd2);
        chk("err.word_kept", word, 32'hFF7F_FFF0);
        apply(64'h0000_0000_0000_0033, 32, "r3_after_err");
        chk("err.r3_idx", idx, 4'd3);

        // sclk activity with le high is ignored; then a zero-length frame.
        wv0 = wv_cnt; fe0 = fe_cnt;
        for (int i = 0; i < 8; i++) begin
            data = i[0];
            #50 sclk = 1'b1;
            #50 sclk = 1'b0;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("idle_sclk.wv", wv_cnt - wv0, 0);
        chk("idle_sclk.fe", fe_cnt - fe0, 0);
        apply(64'd0, 0, "zero_len");

        for (int i = 0; i < 40; i++) begin
            int r;
            int n;
            logic [63:0] b;
            r = int'($urandom_range(0, 9));
            n = (r == 0) ? 31 : (r == 1) ? 33 : 32;
            b = {$urandom, $urandom};
            apply(b, n, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a frame, then le rises without a fall.
        le = 1'b0;
        #100;
        for (int i = 0; i < 16; i++) begin
            data = i[1];
            #50 sclk = 1'b1;
            #50 sclk = 1'b0;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wv0 = wv_cnt; fe0 = fe_cnt;
        le = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst.wv", wv_cnt - wv0, 0);
        chk("midrst.fe", fe_cnt - fe0, 0);
        check_outputs("midrst");
        apply(64'h0000_0000_8F8C_0000, 32, "after_rst");

        // Error counter saturation.
        fe0 = fe_cnt;
        for (int i = 0; i < 257; i++) begin
            send_frame(64'd0, 0);
            model_frame(64'd0, 0);
        end
        chk("sat.fe_pulses", fe_cnt - fe0, 257);
        chk("sat.err_cnt", err_cnt, 8'd255);
        check_outputs("sat");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
